// File: rtl/seq101_state_tracker.sv
// State register and status tracking for the overlapping "101" detector (Moore match in D).
// Define SEQ101_MATCH_INDEX_EN to add the accepted-bit index counter and the last_match_idx output.
module seq101_state_tracker #(
   parameter int CNT_W = 8,
   parameter int IDX_W = 16
) (
   input  logic             clk,
   input  logic             aresetn,
   input  logic             clr,
   input  logic             in_valid,
   input  logic             in,
   output logic [1:0]       state,
   output logic             match,
   output logic [CNT_W-1:0] match_count,
   output logic             overflow
`ifdef SEQ101_MATCH_INDEX_EN
   ,
   output logic [IDX_W-1:0] last_match_idx
`endif
);

   typedef enum logic [1:0] {
      ST_A = 2'd0,
      ST_B = 2'd1,
      ST_C = 2'd2,
      ST_D = 2'd3
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic             match_d;
   logic             overflow_d;
   logic [CNT_W-1:0] count_d;
   logic             accept;

   // A bit only counts when it is qualified and not discarded by a clear.
   assign accept = in_valid & ~clr;

   always_comb begin
      state_d = state_q;
      if (clr) begin
         state_d = ST_A;
      end else if (in_valid) begin
         case (state_q)
            ST_A:    state_d = in ? ST_B : ST_A;
            ST_B:    state_d = in ? ST_B : ST_C;
            ST_C:    state_d = in ? ST_D : ST_A;
            ST_D:    state_d = in ? ST_B : ST_C;
            default: state_d = ST_A;
         endcase
      end
   end

   // Entry into D is the match; D is always left on the next accepted bit, so the pulse is single-cycle.
   always_comb begin
      match_d    = 1'b0;
      count_d    = match_count;
      overflow_d = overflow;
      if (clr) begin
         count_d    = '0;
         overflow_d = 1'b0;
      end else if (accept && (state_d == ST_D)) begin
         match_d = 1'b1;
         if (&match_count) begin
            overflow_d = 1'b1;
         end else begin
            count_d = match_count + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= ST_A;
         match       <= 1'b0;
         match_count <= '0;
         overflow    <= 1'b0;
      end else begin
         state_q     <= state_d;
         match       <= match_d;
         match_count <= count_d;
         overflow    <= overflow_d;
      end
   end

   assign state = state_q;

`ifdef SEQ101_MATCH_INDEX_EN
   logic [IDX_W-1:0] bit_idx;
   logic [IDX_W-1:0] bit_idx_d;
   logic [IDX_W-1:0] last_idx_d;

   // The captured index is the pre-increment value, i.e. the index of the bit that completed the match.
   always_comb begin
      bit_idx_d  = bit_idx;
      last_idx_d = last_match_idx;
      if (clr) begin
         bit_idx_d  = '0;
         last_idx_d = '0;
      end else if (accept) begin
         bit_idx_d = bit_idx + IDX_W'(1);
         if (match_d) begin
            last_idx_d = bit_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         bit_idx        <= '0;
         last_match_idx <= '0;
      end else begin
         bit_idx        <= bit_idx_d;
         last_match_idx <= last_idx_d;
      end
   end
`endif

endmodule

// File: tb/tb_seq101_state_tracker.sv
// Scoreboard bench for seq101_state_tracker, built with CNT_W=2 and IDX_W=3 so saturation and index wrap are reachable.
// A history-based reference model predicts each cycle; predictions are queued at drive time and popped after the edge.
module tb_seq101_state_tracker;

   localparam int CNT_W   = 2;
   localparam int IDX_W   = 3;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   localparam int IDX_MOD = (1 << IDX_W);

   typedef struct {
      int st;
      int mt;
      int cnt;
      int ovf;
      int lidx;
   } exp_t;

   logic             clk;
   logic             aresetn;
   logic             clr;
   logic             in_valid;
   logic             din;
   logic [1:0]       state;
   logic             match;
   logic [CNT_W-1:0] match_count;
   logic             overflow;
`ifdef SEQ101_MATCH_INDEX_EN
   logic [IDX_W-1:0] last_match_idx;
`endif

   exp_t     sb_q[$];
   int       total = 0;
   int       bad   = 0;
   int       step  = 0;

   logic [2:0] m_hist;
   int         m_count;
   int         m_ovf;
   int         m_bidx;
   int         m_lidx;

   seq101_state_tracker #(
      .CNT_W(CNT_W),
      .IDX_W(IDX_W)
   ) dut (
      .clk        (clk),
      .aresetn    (aresetn),
      .clr        (clr),
      .in_valid   (in_valid),
      .in         (din),
      .state      (state),
      .match      (match),
      .match_count(match_count),
      .overflow   (overflow)
`ifdef SEQ101_MATCH_INDEX_EN
      ,
      .last_match_idx(last_match_idx)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int obs, input int exp);
      total++;
      if (obs != exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      m_hist  = 3'b000;
      m_count = 0;
      m_ovf   = 0;
      m_bidx  = 0;
      m_lidx  = 0;
   endtask

   // State is read off the accepted-bit history rather than a transition table.
   function automatic int modelState();
      if (m_hist == 3'b101)          return 3;
      else if (m_hist[0])            return 1;
      else if (m_hist[1:0] == 2'b10) return 2;
      else                           return 0;
   endfunction

   task automatic applyStimulus(input bit c, input bit v, input bit b);
      exp_t e;
      exp_t got;
      int   mt;
      @(negedge clk);
      clr      = c;
      in_valid = v;
      din      = b;
      mt       = 0;
      if (c) begin
         modelReset();
      end else if (v) begin
         m_hist = {m_hist[1:0], b};
         if (m_hist == 3'b101) begin
            mt = 1;
            if (m_count == CNT_MAX) m_ovf = 1;
            else m_count++;
            m_lidx = m_bidx;
         end
         m_bidx = (m_bidx + 1) % IDX_MOD;
      end
      e.st   = modelState();
      e.mt   = mt;
      e.cnt  = m_count;
      e.ovf  = m_ovf;
      e.lidx = m_lidx;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      step++;
      got = sb_q.pop_front();
      checkOutput($sformatf("state@%0d", step), int'(state), got.st);
      checkOutput($sformatf("match@%0d", step), int'(match), got.mt);
      checkOutput($sformatf("count@%0d", step), int'(match_count), got.cnt);
      checkOutput($sformatf("ovf@%0d", step), int'(overflow), got.ovf);
`ifdef SEQ101_MATCH_INDEX_EN
      checkOutput($sformatf("lidx@%0d", step), int'(last_match_idx), got.lidx);
`endif
   endtask

   task automatic acceptBits(input logic [15:0] bits, input int n, input bit gaps);
      for (int i = n - 1; i >= 0; i--) begin
         applyStimulus(1'b0, 1'b1, bits[i]);
         if (gaps && i != 0) applyStimulus(1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, ".state"}, int'(state), 0);
      checkOutput({tag, ".match"}, int'(match), 0);
      checkOutput({tag, ".count"}, int'(match_count), 0);
      checkOutput({tag, ".ovf"}, int'(overflow), 0);
`ifdef SEQ101_MATCH_INDEX_EN
      checkOutput({tag, ".lidx"}, int'(last_match_idx), 0);
`endif
   endtask

   initial begin
      aresetn  = 1'b0;
      clr      = 1'b0;
      in_valid = 1'b0;
      din      = 1'b0;
      modelReset();
      #12;
      checkResetValues("por");
      @(negedge clk);
      aresetn = 1'b1;

      $display("[TB] basic 101 then idle");
      acceptBits(16'b101, 3, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1);

      $display("[TB] gapped 10101");
      applyStimulus(1'b1, 1'b0, 1'b0);
      acceptBits(16'b10101, 5, 1'b1);

      $display("[TB] saturation with five overlapping matches");
      applyStimulus(1'b1, 1'b0, 1'b0);
      acceptBits(16'b10101010101, 11, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1);

      $display("[TB] clear beats an accepted completing bit");
      acceptBits(16'b10, 2, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1);

      $display("[TB] match index capture and wrap");
      acceptBits(16'b0101, 4, 1'b0);
      acceptBits(16'b01, 2, 1'b0);
      acceptBits(16'b101, 3, 1'b0);

      $display("[TB] asynchronous reset mid-stream");
      acceptBits(16'b10, 2, 1'b0);
      @(posedge clk);
      #3;
      aresetn = 1'b0;
      #1;
      checkResetValues("async");
      modelReset();
      @(negedge clk);
      @(negedge clk);
      aresetn = 1'b1;
      acceptBits(16'b101, 3, 1'b0);

      $display("[TB] random traffic");
      for (int i = 0; i < 80; i++) begin
         applyStimulus($urandom_range(15) == 0, $urandom_range(3) != 0, $urandom_range(1) == 1);
      end

      if (sb_q.size() != 0) checkOutput("sb_empty", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
